// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths and request/response types for the memory request master
package mem_if_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_TAG_WIDTH  = 4;
    localparam int MEM_RSP_DEPTH  = 4;

    typedef struct packed {
        logic                      write;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
        logic [MEM_TAG_WIDTH-1:0]  tag;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] rdata;
        logic [MEM_TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/mem_req_master_if.sv
// rtl/mem_req_master_if.sv - request, response and memory-port signals of mem_req_master
interface mem_req_master_if import mem_if_pkg::*; #(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [TAG_WIDTH-1:0]  rsp_tag;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_tag,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_tag,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_tag,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - synchronous response FIFO with occupancy count
module mem_rsp_fifo import mem_if_pkg::*; #(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = MEM_RSP_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  T                     i_wdata,
    output T                     o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mem_req_master.sv
// rtl/mem_req_master.sv - credit-checked request master for a one-cycle-latency synchronous memory
module mem_req_master import mem_if_pkg::*; #(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
    parameter int RSP_DEPTH  = MEM_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    mem_req_master_if.master  bus
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    logic                  w_fire;
    logic                  w_rd_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_credit_used;
    rsp_t                  w_push_data;
    rsp_t                  w_head;

    logic                  r_rd_inflight;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    // A read in flight already owns a FIFO slot; a pop only frees credit on the next cycle.
    assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_rd_inflight};
    assign bus.req_ready = !rst && (w_credit_used < (CW+1)'(RSP_DEPTH));

    assign w_fire    = bus.req_valid && bus.req_ready;
    assign w_rd_fire = w_fire && !bus.req_write;

    assign bus.mem_addr  = w_fire ? bus.req_addr  : r_addr;
    assign bus.mem_wdata = w_fire ? bus.req_wdata : r_wdata;
    assign bus.mem_we    = w_fire && bus.req_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_inflight <= 1'b0;
            r_tag         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else begin
            r_rd_inflight <= w_rd_fire;
            if (w_rd_fire) r_tag <= bus.req_tag;
            if (w_fire) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
        end
    end

    assign w_push      = r_rd_inflight;
    assign w_push_data = '{rdata: bus.mem_rdata, tag: r_tag};
    assign w_pop       = bus.rsp_valid && bus.rsp_ready;

    mem_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_rdata = w_head.rdata;
    assign bus.rsp_tag   = w_head.tag;
    assign bus.busy      = r_rd_inflight || !w_empty;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_mem_req_master.sv
// tb/tb_mem_req_master.sv - scoreboard bench for mem_req_master with a behavioural synchronous memory
module tb_mem_req_master;
    import mem_if_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    mem_req_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port memory: registered read, old data on same-cycle write.
    logic [DW-1:0] mem [256];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = DW'(i * 17);
            mem_loaded = 1'b1;
        end
        bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rsp_mode = 0;
    bit   chk_lat = 1'b0;
    int   we_cnt = 0;
    int   valid_cnt = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [TW-1:0] t, input logic [DW-1:0] exp);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_tag   = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                if (!wr) begin
                    e.rdata = exp;
                    e.tag   = t;
                    e.acc   = cyc;
                    q.push_back(e);
                end
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: req_ready low for 50 cycles at addr 0x%0h, expected high", a);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) begin
                @(posedge clk); #1;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: %0d responses still outstanding, expected 0", name, q.size());
    endtask

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = ~bus.rsp_ready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every response handshake and checks hold-while-stalled.
    initial begin : monitor
        exp_t          e;
        logic          stall_prev = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic [TW-1:0] prev_t = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_we)    we_cnt++;
            if (bus.rsp_valid) valid_cnt++;
            if (bus.busy)      busy_cnt++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
                    check("rsp_hold_payload", 64'({bus.rsp_rdata, bus.rsp_tag}), 64'({prev_d, prev_t}));
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got tag 0x%0h data 0x%0h, expected no response",
                                 bus.rsp_tag, bus.rsp_rdata);
                    end else begin
                        e = q.pop_front();
                        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
                        if (chk_lat) check("rsp_latency", 64'(cyc - e.acc), 64'd2);
                    end
                end
                stall_prev = bus.rsp_valid && !bus.rsp_ready;
                prev_d     = bus.rsp_rdata;
                prev_t     = bus.rsp_tag;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  c0;
        int  w0;
        int  v0;
        int  b0;
        int  acc;
        bit  found;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_tag   = '0;

        repeat (3) @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h1234;
        bus.req_wdata = 32'h55AA55AA;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        bus.req_valid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        idle(2);

        // Write then read-after-write, exact latency.
        chk_lat = 1'b1;
        w0 = we_cnt;
        send(1'b1, 16'h0010, 32'hDEADBEEF, 4'h0, 32'h0);
        send(1'b0, 16'h0010, 32'h0, 4'h3, 32'hDEADBEEF);
        idle(4);
        check("t1_we_pulses", 64'(we_cnt - w0), 64'd1);
        check("t1_drained", 64'(q.size()), 64'd0);

        // Eight back-to-back reads.
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(1'b0, AW'(i), 32'h0, TW'(i), DW'(i * 17));
        check("t2_issue_cycles", 64'(cyc - c0), 64'd8);
        wait_drain("t2_drain");
        chk_lat = 1'b0;

        // Response backpressure fills the credit window.
        rsp_mode = 1;
        idle(2);
        acc = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.req_addr = AW'(acc);
            bus.req_tag  = TW'(acc);
            @(negedge clk);
            if (bus.req_ready) begin
                q.push_back('{rdata: DW'(acc * 17), tag: TW'(acc), acc: cyc});
                acc++;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        check("t3_accepted", 64'(acc), 64'd4);
        check("t3_ready_low", 64'(bus.req_ready), 64'd0);
        rsp_mode = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) found = 1'b1;
        end
        check("t3_first_pop_seen", 64'(found), 64'd1);
        check("t3_ready_at_pop", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("t3_ready_after_pop", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        wait_drain("t3_drain");

        // Toggling rsp_ready across 20 reads; pointers wrap several times.
        rsp_mode = 2;
        for (int i = 0; i < 20; i++) send(1'b0, AW'(32 + i), 32'h0, TW'(i), DW'((32 + i) * 17));
        wait_drain("t4_drain");
        rsp_mode = 0;
        idle(2);

        // Reset with one read in flight and two responses queued.
        rsp_mode = 1;
        idle(2);
        send(1'b0, 16'h0001, 32'h0, 4'h1, DW'(17));
        send(1'b0, 16'h0002, 32'h0, 4'h2, DW'(34));
        send(1'b0, 16'h0003, 32'h0, 4'h3, DW'(51));
        bus.req_valid = 1'b0;
        check("t5_pre_busy", 64'(bus.busy), 64'd1);
        check("t5_pre_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0055;
        bus.req_wdata = 32'h12345678;
        #1 rst = 1'b1;
        #1;
        check("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("t5_rst_mem_we", 64'(bus.mem_we), 64'd0);
        q.delete();
        bus.req_valid = 1'b0;
        rsp_mode = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(5);
        check("t5_no_stale", 64'(bus.rsp_valid), 64'd0);
        chk_lat = 1'b1;
        send(1'b0, 16'h0005, 32'h0, 4'h9, DW'(5 * 17));
        idle(4);
        check("t5_new_read_done", 64'(q.size()), 64'd0);
        chk_lat = 1'b0;

        // Writes only under response backpressure.
        rsp_mode = 1;
        idle(2);
        w0 = we_cnt;
        v0 = valid_cnt;
        b0 = busy_cnt;
        c0 = cyc;
        for (int i = 0; i < 10; i++) send(1'b1, AW'(48 + i), 32'hA5000000 + DW'(i), 4'h0, 32'h0);
        check("t6_issue_cycles", 64'(cyc - c0), 64'd10);
        idle(2);
        check("t6_we_pulses", 64'(we_cnt - w0), 64'd10);
        check("t6_no_rsp_valid", 64'(valid_cnt - v0), 64'd0);
        check("t6_no_busy", 64'(busy_cnt - b0), 64'd0);
        rsp_mode = 0;
        idle(2);
        send(1'b0, 16'h0035, 32'h0, 4'hC, 32'hA5000005);
        wait_drain("t6_readback");

        check("final_queue_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
